// File: rtl/w5300_bus_sequencer_if.sv
// Host-side request/acknowledge bundle between the QL address decoder and the W5300 sequencer.
interface w5300_bus_sequencer_if;
  logic       soft_reset;
  logic       req;
  logic       req_we;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       ready;
  logic       busy;

  modport master (
    output soft_reset, req, req_we, req_addr, req_wdata,
    input  ack, rdata, ready, busy
  );

  modport slave (
    input  soft_reset, req, req_we, req_addr, req_wdata,
    output ack, rdata, ready, busy
  );
endinterface

// File: rtl/w5300_bus_sequencer.sv
// W5300 bus sequencer: owns the chip reset pulse, gates host access until ready and
// runs timed CS/RD/WR cycles. Define W5300_POST_RESET_WAIT_EN to add a post-reset PLL wait.
module w5300_bus_sequencer #(
  parameter int RESET_CYCLES   = 176,
  parameter int WAIT_CYCLES    = 16,
  parameter int STROBE_CYCLES  = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        resetl,
  w5300_bus_sequencer_if.slave        host,
  output logic                        w5300_resetl,
  output logic                        w5300_csl,
  output logic                        w5300_rdl,
  output logic                        w5300_wrl,
  output logic [9:0]                  w5300_addr,
  output logic [7:0]                  w5300_data_out,
  output logic                        w5300_data_oe,
  input  logic [7:0]                  w5300_data_in
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK,
    RECOVER
  } state_t;

  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] RECOVER_LAST = 16'(RECOVER_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        pending_reg, pending_next;
  logic        we_reg, we_next;
  logic [9:0]  addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  rdata_reg, rdata_next;

  logic        resetl_reg, csl_reg, rdl_reg, wrl_reg, oe_reg, ack_reg, ready_reg, busy_reg;
  logic        resetl_next, csl_next, rdl_next, wrl_next, oe_next, ack_next, ready_next, busy_next;
  logic        in_access;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg | host.soft_reset;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;

    case (state_reg)
      RST_HOLD: begin
        pending_next = 1'b0;
        if (host.soft_reset) begin
          cnt_next = '0;
        end else if (cnt_reg == RESET_LAST) begin
          cnt_next = '0;
`ifdef W5300_POST_RESET_WAIT_EN
          state_next = RST_WAIT;
`else
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RST_WAIT: begin
        pending_next = 1'b0;
        if (host.soft_reset) begin
          state_next = RST_HOLD;
          cnt_next   = '0;
        end else if (cnt_reg == WAIT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      IDLE: begin
        cnt_next = '0;
        // A pending reset beats a simultaneous request; the request simply waits.
        if (pending_reg || host.soft_reset) begin
          state_next   = RST_HOLD;
          pending_next = 1'b0;
        end else if (host.req) begin
          state_next = SETUP;
          we_next    = host.req_we;
          addr_next  = host.req_addr;
          wdata_next = host.req_wdata;
        end
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = '0;
      end
      STROBE: begin
        if (cnt_reg == STROBE_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
          if (!we_reg) begin
            rdata_next = w5300_data_in;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      HOLD: begin
        state_next = ACK;
      end
      ACK: begin
        state_next = RECOVER;
        cnt_next   = '0;
      end
      RECOVER: begin
        if (cnt_reg == RECOVER_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = RST_HOLD;
        cnt_next   = '0;
      end
    endcase

    // Pins are decoded from the next state so they leave the flops glitch-free.
    in_access   = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    resetl_next = (state_next != RST_HOLD);
    csl_next    = !in_access;
    rdl_next    = !((state_next == STROBE) && !we_next);
    wrl_next    = !((state_next == STROBE) && we_next);
    oe_next     = in_access && we_next;
    ack_next    = (state_next == ACK);
    ready_next  = (state_next != RST_HOLD) && (state_next != RST_WAIT);
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_reg   <= RST_HOLD;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      resetl_reg  <= 1'b0;
      csl_reg     <= 1'b1;
      rdl_reg     <= 1'b1;
      wrl_reg     <= 1'b1;
      oe_reg      <= 1'b0;
      ack_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      resetl_reg  <= resetl_next;
      csl_reg     <= csl_next;
      rdl_reg     <= rdl_next;
      wrl_reg     <= wrl_next;
      oe_reg      <= oe_next;
      ack_reg     <= ack_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
    end
  end

  assign w5300_resetl   = resetl_reg;
  assign w5300_csl      = csl_reg;
  assign w5300_rdl      = rdl_reg;
  assign w5300_wrl      = wrl_reg;
  assign w5300_addr     = addr_reg;
  assign w5300_data_out = wdata_reg;
  assign w5300_data_oe  = oe_reg;
  assign host.ack       = ack_reg;
  assign host.rdata     = rdata_reg;
  assign host.ready     = ready_reg;
  assign host.busy      = busy_reg;

endmodule

// File: tb/tb_w5300_bus_sequencer.sv
// Bench for w5300_bus_sequencer: per-cycle pin comparison against a timing model plus directed literal checks.
module tb_w5300_bus_sequencer;
  localparam int RESET_CYCLES   = 176;
  localparam int WAIT_CYCLES    = 16;
  localparam int STROBE_CYCLES  = 3;
  localparam int RECOVER_CYCLES = 2;
`ifdef W5300_POST_RESET_WAIT_EN
  localparam int READY_AT = RESET_CYCLES + WAIT_CYCLES;
`else
  localparam int READY_AT = RESET_CYCLES;
`endif
  localparam int S       = STROBE_CYCLES;
  localparam int ACC_END = STROBE_CYCLES + RECOVER_CYCLES + 4;

  logic       clk = 1'b0;
  logic       resetl = 1'b1;
  logic       w5300_resetl, w5300_csl, w5300_rdl, w5300_wrl, w5300_data_oe;
  logic [9:0] w5300_addr;
  logic [7:0] w5300_data_out;
  logic [7:0] w5300_data_in = 8'h00;
  bit         din_rand = 1'b1;
  bit         cmp_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  w5300_bus_sequencer_if host ();

  w5300_bus_sequencer #(
    .RESET_CYCLES  (RESET_CYCLES),
    .WAIT_CYCLES   (WAIT_CYCLES),
    .STROBE_CYCLES (STROBE_CYCLES),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .clk           (clk),
    .resetl        (resetl),
    .host          (host),
    .w5300_resetl  (w5300_resetl),
    .w5300_csl     (w5300_csl),
    .w5300_rdl     (w5300_rdl),
    .w5300_wrl     (w5300_wrl),
    .w5300_addr    (w5300_addr),
    .w5300_data_out(w5300_data_out),
    .w5300_data_oe (w5300_data_oe),
    .w5300_data_in (w5300_data_in)
  );

  always #5 clk = ~clk;

  // Timing model: reset age in edges, access age in cycles since the acceptance edge.
  bit         m_in_reset = 1'b1;
  int         m_age = 0;
  bit         m_acc = 1'b0;
  int         m_t = 0;
  bit         m_we = 1'b0;
  bit         m_pend = 1'b0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_rdata = '0;

  initial forever begin
    @(posedge clk or negedge resetl);
    if (!resetl) begin
      m_in_reset = 1'b1; m_age = 0; m_acc = 1'b0; m_t = 0; m_we = 1'b0; m_pend = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_in_reset) begin
      if (host.soft_reset) m_age = 0;
      else begin
        m_age++;
        if (m_age == READY_AT) m_in_reset = 1'b0;
      end
    end else if (m_acc) begin
      if (host.soft_reset) m_pend = 1'b1;
      m_t++;
      if (m_t == S + 2 && !m_we) m_rdata = w5300_data_in;
      if (m_t == ACC_END) m_acc = 1'b0;
    end else if (m_pend || host.soft_reset) begin
      m_in_reset = 1'b1; m_age = 0; m_pend = 1'b0;
    end else if (host.req) begin
      m_acc = 1'b1; m_t = 1; m_we = host.req_we; m_addr = host.req_addr; m_wdata = host.req_wdata;
    end
  end

  function automatic logic [33:0] expect_vec();
    logic cs, st;
    cs = m_acc && (m_t >= 1) && (m_t <= S + 2);
    st = m_acc && (m_t >= 2) && (m_t <= S + 1);
    return {!(m_in_reset && m_age < RESET_CYCLES), !cs, !(st && !m_we), !(st && m_we),
            cs && m_we, m_acc && (m_t == S + 3), !m_in_reset, m_in_reset || m_acc,
            m_addr, m_wdata, m_rdata};
  endfunction

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [33:0] act, req;
      act = {w5300_resetl, w5300_csl, w5300_rdl, w5300_wrl, w5300_data_oe, host.ack, host.ready,
             host.busy, w5300_addr, w5300_data_out, host.rdata};
      req = expect_vec();
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL pins t=%0t actual=%h required=%h", $time, act, req);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (din_rand) w5300_data_in = 8'($urandom);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge; raise_at >= 0 raises the preset request at that sample.
  task automatic wait_ready(input int raise_at, output int low_cnt, output int ready_at,
                            output int strobe_lo);
    low_cnt = 0; ready_at = -1; strobe_lo = 0;
    for (int k = 0; k <= READY_AT + 10; k++) begin
      if (k > 0) @(negedge clk);
      if (!w5300_resetl) low_cnt++;
      if (!w5300_rdl || !w5300_wrl || !w5300_csl || host.ack) strobe_lo++;
      if (host.ready) begin
        ready_at = k;
        break;
      end
      if (k == raise_at) host.req = 1'b1;
    end
    if (ready_at < 0) check("ready_timeout", 0, 1);
  endtask

  // Called at a negedge with the sequencer idle; returns at the first idle sample after recovery.
  task automatic access(input bit we, input logic [9:0] a, input logic [7:0] d, input int soft_at,
                        output int ack_at, output int csl_lo, output int rdl_lo,
                        output int wrl_lo, output int oe_lo, output int ack_cnt);
    host.req = 1'b1; host.req_we = we; host.req_addr = a; host.req_wdata = d;
    ack_at = -1; csl_lo = 0; rdl_lo = 0; wrl_lo = 0; oe_lo = 0; ack_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!w5300_csl) csl_lo++;
      if (!w5300_rdl) rdl_lo++;
      if (!w5300_wrl) wrl_lo++;
      if (w5300_data_oe) oe_lo++;
      if (host.ack) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = k;
        host.req = 1'b0;
      end
      host.soft_reset = (k == soft_at);
      if (ack_at >= 0 && k >= ack_at + RECOVER_CYCLES + 1) break;
    end
    host.req = 1'b0;
    host.soft_reset = 1'b0;
    if (ack_at < 0) check("ack_timeout", 0, 1);
  endtask

  initial begin
    int lo, rdy, stb, aa, cl, rl, wl, ol, ac, mode;
    logic [9:0] ra;
    logic [7:0] rd;
    bit rw;
    host.soft_reset = 1'b0; host.req = 1'b0; host.req_we = 1'b0;
    host.req_addr = '0; host.req_wdata = '0;
    #1 resetl = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_w5300_resetl", int'(w5300_resetl), 0);
    check("rst_csl", int'(w5300_csl), 1);
    check("rst_busy", int'(host.busy), 1);
    check("rst_ready", int'(host.ready), 0);
    check("rst_ack", int'(host.ack), 0);
    check("rst_rdata", int'(host.rdata), 0);

    // Request held from before reset release: nothing until ready, then one access.
    host.req = 1'b1; host.req_we = 1'b0; host.req_addr = 10'h2AA; host.req_wdata = 8'h00;
    resetl = 1'b1;
    wait_ready(-1, lo, rdy, stb);
    check("por_resetl_low", lo, RESET_CYCLES);
    check("por_ready_at", rdy, READY_AT);
    check("por_no_strobe", stb, 0);
    access(1'b0, 10'h2AA, 8'h00, -1, aa, cl, rl, wl, ol, ac);
    check("held_req_acks", ac, 1);

    // Directed read of 0x3FE returning 0x5A.
    din_rand = 1'b0; w5300_data_in = 8'h5A;
    access(1'b0, 10'h3FE, 8'h00, -1, aa, cl, rl, wl, ol, ac);
    check("rd_csl_low", cl, 5);
    check("rd_rdl_low", rl, 3);
    check("rd_wrl_low", wl, 0);
    check("rd_ack_cnt", ac, 1);
    check("rd_ack_at", aa, 6);
    check("rd_rdata", int'(host.rdata), 8'h5A);
    din_rand = 1'b1;

    // Directed write of 0x12 to 0x001.
    access(1'b1, 10'h001, 8'h12, -1, aa, cl, rl, wl, ol, ac);
    check("wr_addr", int'(w5300_addr), 10'h001);
    check("wr_data_out", int'(w5300_data_out), 8'h12);
    check("wr_oe_cycles", ol, 5);
    check("wr_wrl_low", wl, 3);
    check("wr_rdl_low", rl, 0);
    check("wr_ack_cnt", ac, 1);

    // Soft reset during the strobe of a read; a request raised mid-reset waits for ready.
    access(1'b0, 10'h155, 8'h00, 2, aa, cl, rl, wl, ol, ac);
    check("sr_ack_cnt", ac, 1);
    @(negedge clk);
    host.req_we = 1'b0; host.req_addr = 10'h0F0; host.req_wdata = 8'h00;
    wait_ready(50, lo, rdy, stb);
    check("sr_resetl_low", lo, RESET_CYCLES);
    check("sr_ready_at", rdy, READY_AT);
    check("sr_no_strobe", stb, 0);
    access(1'b0, 10'h0F0, 8'h00, -1, aa, cl, rl, wl, ol, ac);
    check("sr_late_ack_cnt", ac, 1);

    // Randomized traffic with occasional soft resets.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rw = 1'($urandom); ra = 10'($urandom); rd = 8'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        access(rw, ra, rd, $urandom_range(1, 8), aa, cl, rl, wl, ol, ac);
        check("rnd_soft_ack_cnt", ac, 1);
        @(negedge clk);
        wait_ready(-1, lo, rdy, stb);
      end else if (mode == 1) begin
        host.req = 1'b1; host.req_we = rw; host.req_addr = ra; host.req_wdata = rd;
        host.soft_reset = 1'b1;
        @(negedge clk);
        host.soft_reset = 1'b0;
        check("rnd_reset_wins", int'(host.ready), 0);
        wait_ready(-1, lo, rdy, stb);
        check("rnd_idle_reset_low", lo, RESET_CYCLES);
        access(rw, ra, rd, -1, aa, cl, rl, wl, ol, ac);
        check("rnd_held_ack_cnt", ac, 1);
      end else begin
        access(rw, ra, rd, -1, aa, cl, rl, wl, ol, ac);
        check("rnd_ack_at", aa, S + 3);
        check("rnd_ack_cnt", ac, 1);
      end
    end

    // Asynchronous reset in the middle of a write strobe.
    host.req = 1'b1; host.req_we = 1'b1; host.req_addr = 10'h0AA; host.req_wdata = 8'hA5;
    repeat (3) @(negedge clk);
    check("abort_wrl_before", int'(w5300_wrl), 0);
    #2 resetl = 1'b0;
    host.req = 1'b0;
    #1;
    check("abort_wrl", int'(w5300_wrl), 1);
    check("abort_csl", int'(w5300_csl), 1);
    check("abort_ack", int'(host.ack), 0);
    check("abort_w5300_resetl", int'(w5300_resetl), 0);
    ac = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (host.ack) ac++;
    end
    resetl = 1'b1;
    wait_ready(-1, lo, rdy, stb);
    check("abort_no_ack", ac + stb, 0);
    check("abort_resetl_low", lo, RESET_CYCLES);
    check("abort_ready_at", rdy, READY_AT);
    access(1'b0, 10'h3C3, 8'h00, -1, aa, cl, rl, wl, ol, ac);
    check("post_abort_ack_cnt", ac, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
